// File: rtl/oisc_fetch_unit_pkg.sv
// Shared definitions for the OISC instruction fetch unit.
//   InstructionWidth : default instruction width ({src,dst} move halves)
//   PCRegWidth       : default fetch PC / memory address width
//   OISC_PCStep      : default byte increment between sequential fetches
//   OISC_FetchDepth  : default prefetch FIFO depth (power of 2, >= 2)
//   OISC_BootAddr    : default fetch PC after RST or soft Reset
//   fetch_state_e    : IDLE/RUN state encoding of the fetch FSM
//   cnt_w()          : width of occupancy/credit counters for a given depth
package oisc_fetch_unit_pkg;

  localparam int          InstructionWidth = 32;
  localparam int          PCRegWidth       = 32;
  localparam int          OISC_PCStep      = 4;
  localparam int          OISC_FetchDepth  = 4;
  localparam logic [31:0] OISC_BootAddr    = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // Counters must be able to hold the value DEPTH itself, not just DEPTH-1.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/oisc_fetch_unit_fifo.sv
// Prefetch FIFO: DEPTH entries of W bits, synchronous push/pop/flush.
// Ports:
//   CLK, RST   : clock, asynchronous active-high reset (storage cleared to 0)
//   push       : write push_data at the tail
//   push_data  : entry to store
//   pop        : drop the head entry (caller guarantees not empty)
//   flush      : discard every entry; takes priority over push/pop
//   count      : current occupancy
//   empty      : occupancy is zero
//   head_data  : oldest entry (registered storage, no read latency)
// Overflow is prevented by the caller's credit scheme, so push is never
// qualified against a full condition here.
module oisc_fetch_unit_fifo
  import oisc_fetch_unit_pkg::*;
#(
  parameter int DEPTH = OISC_FetchDepth,
  parameter int W     = 64,
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic [W-1:0]  head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/oisc_fetch_unit.sv
// Instruction fetch stage feeding the OISC move core.
// Generates sequential fetch addresses, issues ready/valid requests to
// instruction memory, buffers in-order responses in a prefetch FIFO and hands
// {src,dst} move instructions to the core. Redirect/Reset flush the stage;
// responses to requests already in flight are drained and discarded.
// Ports:
//   CLK, RST                      : clock, asynchronous active-high reset
//   Start                         : IDLE -> RUN
//   Reset                         : synchronous soft reset (flush, PC:=BOOT_ADDR, IDLE)
//   Redirect, RedirectPC          : core wrote its PC; refetch from RedirectPC
//   MemReqValid/Ready/Addr        : fetch request channel
//   MemRespValid/Ready/Data       : in-order fetch response channel
//   InstrValid/Ready/Data/PC      : instruction delivery to the core
// Build option: OISC_FETCH_BYPASS_EN -- when the FIFO is empty, nothing is
// being dropped and the core is ready, a response is forwarded combinationally
// to InstrData/InstrValid in its arrival cycle instead of being written to the
// FIFO. Without it, InstrValid/InstrData come purely from FIFO registers.
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | no fetch requests issued; waits for Start
// RUN     | requests issued whenever FIFO credit allows
module oisc_fetch_unit
  import oisc_fetch_unit_pkg::*;
#(
  parameter int              INSTR_W   = InstructionWidth,
  parameter int              PC_W      = PCRegWidth,
  parameter int              PC_STEP   = OISC_PCStep,
  parameter int              DEPTH     = OISC_FetchDepth,
  parameter logic [PC_W-1:0] BOOT_ADDR = PC_W'(OISC_BootAddr)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic               Reset,
  input  logic               Redirect,
  input  logic [PC_W-1:0]    RedirectPC,
  output logic               MemReqValid,
  input  logic               MemReqReady,
  output logic [PC_W-1:0]    MemReqAddr,
  input  logic               MemRespValid,
  output logic               MemRespReady,
  input  logic [INSTR_W-1:0] MemRespData,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [INSTR_W-1:0] InstrData,
  output logic [PC_W-1:0]    InstrPC
);

  localparam int              CW      = cnt_w(DEPTH);
  localparam int              EW      = INSTR_W + PC_W;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [PC_W-1:0] STEP_C  = PC_W'(PC_STEP);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            withdraw_q, withdraw_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_head;
  logic            fifo_push, fifo_pop;

  logic            flush, req_fire, rsp_keep, bypass;
  logic [CW:0]     credit_used;
  logic [PC_W-1:0] flush_pc;

  // Entries in the FIFO and requests in flight (including ones that will be
  // dropped) both hold a slot, so the FIFO can never overflow.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outst_q};
  assign MemReqValid = (state_q == ST_RUN) && !withdraw_q && (credit_used < DEPTH_C);
  assign MemReqAddr  = pc_q;
  assign req_fire    = MemReqValid && MemReqReady;

  assign MemRespReady = !RST;

  assign flush    = Reset || Redirect;
  assign flush_pc = Reset ? BOOT_ADDR : RedirectPC;
  // A response is kept only if it answers a request issued after the last
  // flush and does not itself arrive in a flush cycle.
  assign rsp_keep = MemRespValid && (drop_q == '0) && !flush;

`ifdef OISC_FETCH_BYPASS_EN
  assign bypass = !RST && fifo_empty && (drop_q == '0) && InstrReady && MemRespValid;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = rsp_keep && !bypass;
  assign fifo_pop  = !fifo_empty && InstrReady;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    withdraw_d = 1'b0;

    if (req_fire) begin
      pc_d    = pc_q + STEP_C;
      outst_d = outst_q + 1'b1;
    end
    if (MemRespValid) begin
      outst_d = outst_d - 1'b1;
      if (drop_q != '0) begin
        drop_d = drop_q - 1'b1;
      end
    end
    // Responses return in request order and requests are sequential, so the
    // PC of the next kept response is just a second running address.
    if (rsp_keep) begin
      rsp_pc_d = rsp_pc_q + STEP_C;
    end

    if (state_q == ST_IDLE && Start) begin
      state_d = ST_RUN;
    end

    if (flush) begin
      pc_d       = flush_pc;
      rsp_pc_d   = flush_pc;
      drop_d     = outst_d;
      // A request presented but not accepted is pulled back for one cycle
      // so memory never sees the address change under a held valid.
      withdraw_d = MemReqValid && !MemReqReady;
    end

    if (Reset) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      pc_q       <= BOOT_ADDR;
      rsp_pc_q   <= BOOT_ADDR;
      outst_q    <= '0;
      drop_q     <= '0;
      withdraw_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      withdraw_q <= withdraw_d;
    end
  end

  oisc_fetch_unit_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (fifo_push),
    .push_data ({MemRespData, rsp_pc_q}),
    .pop       (fifo_pop),
    .flush     (flush),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .head_data (fifo_head)
  );

  assign InstrValid = !fifo_empty || bypass;
  assign InstrData  = bypass ? MemRespData : fifo_head[EW-1:PC_W];
  assign InstrPC    = bypass ? rsp_pc_q    : fifo_head[PC_W-1:0];

endmodule

// File: tb/tb_oisc_fetch_unit.sv
module tb_oisc_fetch_unit;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] BOOT    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'd4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0, Reset = 1'b0, Redirect = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic        MemReqValid;
  logic        MemReqReady = 1'b0;
  logic [31:0] MemReqAddr;
  logic        MemRespValid = 1'b0;
  logic        MemRespReady;
  logic [31:0] MemRespData = '0;
  logic        InstrValid;
  logic        InstrReady = 1'b0;
  logic [31:0] InstrData, InstrPC;

  always #5 CLK = ~CLK;

  oisc_fetch_unit dut (
    .CLK          (CLK),
    .RST          (RST),
    .Start        (Start),
    .Reset        (Reset),
    .Redirect     (Redirect),
    .RedirectPC   (RedirectPC),
    .MemReqValid  (MemReqValid),
    .MemReqReady  (MemReqReady),
    .MemReqAddr   (MemReqAddr),
    .MemRespValid (MemRespValid),
    .MemRespReady (MemRespReady),
    .MemRespData  (MemRespData),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .InstrData    (InstrData),
    .InstrPC      (InstrPC)
  );

  typedef struct { logic [31:0] addr; bit keep; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;

  req_t        out_q[$];     // model: requests in flight, keep=0 once flushed
  ins_t        exp_q[$];     // scoreboard: instructions the core should receive
  logic [31:0] mem_pend[$];  // memory: accepted addresses awaiting a response
  logic [31:0] m_pc;
  bit          m_run;
  bit          exp_req_valid;
  logic [31:0] exp_req_addr;

  int checks = 0, failures = 0;
  int p_ready = 0, p_resp = 0, p_iready = 0, p_redir = 0, p_reset = 0, p_start = 0;
  bit          fix_pc = 1'b0;
  logic [31:0] fix_pc_val = '0;
  int          fires = 0;
  bit          wrap_seen = 1'b0;
  logic [31:0] last_fire_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    out_q.delete();
    exp_q.delete();
    mem_pend.delete();
    m_pc          = BOOT;
    m_run         = 1'b0;
    exp_req_valid = 1'b0;
    exp_req_addr  = BOOT;
  endtask

  function automatic bit pick(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // One clock: drive at negedge, update memory + reference model at +2.
  task automatic cycle();
    bit   fire, flush, pend;
    req_t r;
    @(negedge CLK);
    MemReqReady  = pick(p_ready);
    InstrReady   = pick(p_iready);
    Start        = pick(p_start);
    Reset        = pick(p_reset);
    Redirect     = pick(p_redir);
    RedirectPC   = fix_pc ? fix_pc_val :
                   ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
    MemRespValid = !RST && (mem_pend.size() > 0) && pick(p_resp);
    MemRespData  = MemRespValid ? mem_word(mem_pend[0]) : $urandom();
    #2;
    if (!RST) begin
      fire  = MemReqValid && MemReqReady;
      flush = Reset || Redirect;
      pend  = MemReqValid && !MemReqReady;
      if (fire) begin
        fires++;
        if (last_fire_addr == 32'hFFFF_FFFC && MemReqAddr == 32'h0) wrap_seen = 1'b1;
        last_fire_addr = MemReqAddr;
        mem_pend.push_back(MemReqAddr);
        out_q.push_back('{addr: m_pc, keep: 1'b1});
        m_pc = m_pc + PC_STEP;
      end
      if (MemRespValid) begin
        void'(mem_pend.pop_front());
        if (out_q.size() > 0) begin
          r = out_q.pop_front();
          if (r.keep && !flush) exp_q.push_back('{pc: r.addr, data: mem_word(r.addr)});
        end
      end
      if (flush) begin
        exp_q.delete();
        foreach (out_q[i]) out_q[i].keep = 1'b0;
        m_pc = Reset ? BOOT : RedirectPC;
      end
      if (Reset) m_run = 1'b0;
      else if (Start) m_run = 1'b1;
      exp_req_valid = m_run && !(flush && pend) && (exp_q.size() + out_q.size() < DEPTH);
      exp_req_addr  = m_pc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic knobs(input int rdy, input int rsp, input int irdy, input int redir,
                       input int rst, input int st);
    p_ready = rdy; p_resp = rsp; p_iready = irdy; p_redir = redir; p_reset = rst; p_start = st;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid",  MemReqValid,  1'b0);
    check("rst_req_addr",   MemReqAddr,   BOOT);
    check("rst_instr_valid", InstrValid,  1'b0);
    check("rst_instr_data", InstrData,    32'h0);
    check("rst_instr_pc",   InstrPC,      32'h0);
    check("rst_resp_ready", MemRespReady, 1'b0);
  endtask

  // Async RST pulse starting between clock edges; the model restarts with it.
  task automatic hard_reset();
    #1 RST = 1'b1;
    model_reset();
    #1 check_reset_outputs();
    run(2);
    #1 RST = 1'b0;
  endtask

  // Monitor: compares DUT outputs with the model every cycle, pops the
  // scoreboard on each accepted instruction.
  initial begin
    ins_t e;
    forever begin
      @(negedge CLK);
      #1;
      if (!RST) begin
        check("req_valid", MemReqValid, exp_req_valid);
        if (MemReqValid && exp_req_valid) check("req_addr", MemReqAddr, exp_req_addr);
        check("instr_valid", InstrValid, exp_q.size() != 0);
        if (InstrValid && InstrReady && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("instr_pc", InstrPC, e.pc);
          check("instr_data", InstrData, e.data);
        end
      end
    end
  end

  initial begin
    model_reset();
    #3 check_reset_outputs();
    run(2);
    #1 RST = 1'b0;

    // Streaming: memory always ready, 1-cycle responses, core always ready.
    knobs(100, 100, 100, 0, 0, 100);
    run(1);
    knobs(100, 100, 100, 0, 0, 0);
    run(30);

    // Credit limit: stalled core -> exactly DEPTH requests, one pop -> one more.
    hard_reset();
    knobs(100, 100, 0, 0, 0, 100);
    run(1);
    fires = 0;
    knobs(100, 100, 0, 0, 0, 0);
    run(12);
    check("credit_fires", fires, 4);
    p_iready = 100;
    run(1);
    p_iready = 0;
    run(6);
    check("credit_refill", fires, 5);

    // Redirect with three requests in flight.
    hard_reset();
    knobs(100, 0, 0, 0, 0, 100);
    run(1);
    p_start = 0;
    run(3);
    p_ready = 0; p_redir = 100; fix_pc = 1'b1; fix_pc_val = 32'h0000_0100;
    run(1);
    knobs(100, 100, 100, 0, 0, 0);
    run(15);

    // Redirect coinciding with a request fire and a response.
    p_redir = 100; fix_pc_val = 32'h0000_0200;
    run(1);
    p_redir = 0;
    run(10);

    // Soft Reset mid-run with two requests in flight, idle, then restart.
    knobs(100, 0, 0, 0, 0, 0);
    p_redir = 100; fix_pc_val = 32'h0000_0040;
    run(1);
    p_redir = 0;
    run(2);
    knobs(0, 0, 100, 0, 100, 0);
    run(1);
    knobs(100, 100, 100, 0, 0, 0);
    run(8);
    p_start = 100;
    run(1);
    p_start = 0;
    run(10);

    // Address wrap at the top of the PC range.
    p_redir = 100; fix_pc_val = 32'hFFFF_FFF8;
    run(1);
    p_redir = 0; fix_pc = 1'b0;
    run(10);
    check("pc_wrap_seen", wrap_seen, 1'b1);

    // Randomized traffic.
    knobs(70, 60, 60, 3, 1, 10);
    run(2500);

    // Async RST in the middle of a burst.
    knobs(100, 100, 100, 0, 0, 100);
    run(1);
    p_start = 0;
    run(5);
    hard_reset();
    p_start = 100;
    run(1);
    p_start = 0;
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
